// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshake signals around mem_port_arbiter.
// The master view belongs to the arbiter; the slave view belongs to the requesters and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_flush;
  logic          i_ready;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, i_flush,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_ack, mem_rdata,
    output i_ready, i_rdata,
    output d_ready, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, i_flush,
    output d_req, d_we, d_addr, d_wdata,
    output mem_ack, mem_rdata,
    input  i_ready, i_rdata,
    input  d_ready, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and data access,
// with fetch-flush draining and a wait-state timeout that aborts a stuck transaction.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                err_timeout
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_WAIT  = 2'd1,
    D_WAIT  = 2'd2,
    I_DRAIN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          rr_last_d_q, rr_last_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic i_cand_c, d_cand_c, grant_i_c, grant_d_c;
  logic timeout_hit_c;
  logic i_ready_c, d_ready_c;

  // Candidates and round-robin winner; a flushed fetch never competes.
  assign i_cand_c      = bus.i_req & ~bus.i_flush;
  assign d_cand_c      = bus.d_req;
  assign grant_d_c     = d_cand_c & (~i_cand_c | ~rr_last_d_q);
  assign grant_i_c     = i_cand_c & (~d_cand_c | rr_last_d_q);
  assign timeout_hit_c = (cnt_q == CNT_LAST) & ~bus.mem_ack;

  // State register and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rr_last_d_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rr_last_d_q <= rr_last_d_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state, grant capture and completion pulses.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rr_last_d_d = rr_last_d_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    i_ready_c   = 1'b0;
    d_ready_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          state_d     = D_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          rr_last_d_d = 1'b1;
          cnt_d       = '0;
        end else if (grant_i_c) begin
          state_d     = I_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.i_addr;
          rr_last_d_d = 1'b0;
          cnt_d       = '0;
        end
      end

      I_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mem_ack || timeout_hit_c) begin
          i_ready_c = ~bus.i_flush;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (timeout_hit_c) err_d = 1'b1;
        end else if (bus.i_flush) begin
          state_d = I_DRAIN;
        end
      end

      I_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mem_ack || timeout_hit_c) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (timeout_hit_c) err_d = 1'b1;
        end
      end

      D_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mem_ack || timeout_hit_c) begin
          d_ready_c = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (timeout_hit_c) err_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Read data is forced to zero on an aborted transaction.
  assign bus.i_ready   = i_ready_c;
  assign bus.d_ready   = d_ready_c;
  assign bus.i_rdata   = bus.mem_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata   = bus.mem_ack ? bus.mem_rdata : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with TIMEOUT=4; memory acks are driven by hand per step.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic err_timeout;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.i_flush   = 1'b0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset values
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
    tick();
    reset = 1'b1;

    // Fetch only, ack in the first mem_req cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    #1;
    chk("t1_idle_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t1_idle_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    chk("t1_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t1_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    chk("t1_d_ready", 32'(bus.d_ready), 32'd0);
    tick();
    bus.i_req   = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("t1_req_drop", 32'(bus.mem_req), 32'd0);
    chk("t1_ready_drop", 32'(bus.i_ready), 32'd0);

    // Both requesting: order D, I, D, I
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'h55;
    tick();
    chk("t2_d1_mem_we", 32'(bus.mem_we), 32'd1);
    chk("t2_d1_mem_addr", bus.mem_addr, 32'h20);
    chk("t2_d1_mem_wdata", bus.mem_wdata, 32'h55);
    bus.mem_ack = 1'b1;
    #1;
    chk("t2_d1_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t2_d1_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h24;
    #1;
    chk("t2_gap1_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("t2_i1_mem_we", 32'(bus.mem_we), 32'd0);
    chk("t2_i1_mem_addr", bus.mem_addr, 32'h200);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11;
    #1;
    chk("t2_i1_i_ready", 32'(bus.i_ready), 32'd1);
    chk("t2_i1_i_rdata", bus.i_rdata, 32'h11);
    chk("t2_i1_d_ready", 32'(bus.d_ready), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.i_addr  = 32'h204;
    tick();
    chk("t2_d2_mem_addr", bus.mem_addr, 32'h24);
    chk("t2_d2_mem_we", 32'(bus.mem_we), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h22;
    #1;
    chk("t2_d2_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t2_d2_d_rdata", bus.d_rdata, 32'h22);
    tick();
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    tick();
    chk("t2_i2_mem_addr", bus.mem_addr, 32'h204);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h33;
    #1;
    chk("t2_i2_i_ready", 32'(bus.i_ready), 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    bus.i_req   = 1'b0;

    // Flush in I_WAIT, ack three cycles later, then pending load
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h300;
    tick();
    chk("t3_mem_addr", bus.mem_addr, 32'h300);
    bus.i_flush = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h40;
    #1;
    chk("t3_flush_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.i_flush = 1'b0;
    bus.i_req   = 1'b0;
    #1;
    chk("t3_drain_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t3_drain_d_ready", 32'(bus.d_ready), 32'd0);
    tick();
    chk("t3_drain2_mem_req", 32'(bus.mem_req), 32'd1);
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD;
    #1;
    chk("t3_ack_i_ready", 32'(bus.i_ready), 32'd0);
    chk("t3_ack_d_ready", 32'(bus.d_ready), 32'd0);
    chk("t3_err", 32'(err_timeout), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t3_idle_mem_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("t3_d_mem_req", 32'(bus.mem_req), 32'd1);
    chk("t3_d_mem_addr", bus.mem_addr, 32'h40);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77;
    #1;
    chk("t3_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t3_d_rdata", bus.d_rdata, 32'h77);
    tick();
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;

    // Flush and ack together in I_WAIT
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h400;
    tick();
    chk("t4_mem_addr", bus.mem_addr, 32'h400);
    bus.i_flush   = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h99;
    #1;
    chk("t4_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.i_flush = 1'b0;
    bus.i_req   = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    chk("t4_idle_mem_req", 32'(bus.mem_req), 32'd0);

    // Timeout on a load
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h80;
    bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    for (int w = 1; w <= 3; w++) begin
      chk("t5_wait_d_ready", 32'(bus.d_ready), 32'd0);
      chk("t5_wait_err", 32'(err_timeout), 32'd0);
      tick();
    end
    chk("t5_abort_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t5_abort_d_rdata", bus.d_rdata, 32'h0);
    chk("t5_abort_mem_req", 32'(bus.mem_req), 32'd1);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("t5_err_set", 32'(err_timeout), 32'd1);
    chk("t5_mem_req_clr", 32'(bus.mem_req), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234;
    #1;
    chk("t5_late_d_ready", 32'(bus.d_ready), 32'd0);
    chk("t5_late_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_err_sticky", 32'(err_timeout), 32'd1);
    chk("t5_late_mem_req", 32'(bus.mem_req), 32'd0);

    // Reset in the middle of D_WAIT
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h90;
    bus.d_wdata = 32'hAB;
    tick();
    chk("t6_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_d_ready", 32'(bus.d_ready), 32'd0);
    chk("t6_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("t6_rst_err", 32'(err_timeout), 32'd0);
    bus.d_req = 1'b0;
    tick();
    reset       = 1'b1;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h500;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'hA0;
    tick();
    chk("t6_first_grant_addr", bus.mem_addr, 32'hA0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A;
    #1;
    chk("t6_first_d_ready", 32'(bus.d_ready), 32'd1);
    chk("t6_first_i_ready", 32'(bus.i_ready), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    bus.d_req   = 1'b0;
    bus.i_req   = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
